// File: rtl/soft_cpu_control_matrix.sv
// Single-cycle 8-bit soft-CPU core: 16 x 8-bit register file, 16-bit instruction pointer,
// ALU ops, conditional/unconditional jumps and LOAD/STORE to an external data memory.
module soft_cpu_control_matrix (
    input  logic        clock,
    input  logic        resetN,
    input  logic [25:0] instruction,
    output logic [15:0] instructionPointer,
    input  logic [15:0] addressIn,
    input  logic [7:0]  valueIn,
    output logic [15:0] addressOut,
    output logic [7:0]  valueOut
);

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_INV   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_JFL   = 4'b0101;
    localparam logic [3:0] OP_JFE   = 4'b0110;
    localparam logic [3:0] OP_JFG   = 4'b0111;
    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1010;

    logic [7:0]  regFile [16];
    logic [15:0] ip;

    logic [3:0]  opcode;
    logic        sel1;
    logic        sel2;
    logic [7:0]  val1;
    logic [7:0]  val2;
    logic [3:0]  dest;
    logic [3:0]  memReg;
    logic [15:0] memAddr;

    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [7:0]  regVal;

    logic        writeEn;
    logic [3:0]  writeIdx;
    logic [7:0]  writeData;
    logic        jumpTaken;

    // The data-memory read address input has no role in this core.
    logic        unusedAddressIn;
    assign unusedAddressIn = ^addressIn;

    assign opcode  = instruction[25:22];
    assign sel1    = instruction[21];
    assign val1    = instruction[20:13];
    assign sel2    = instruction[12];
    assign val2    = instruction[11:4];
    assign dest    = instruction[3:0];
    assign memReg  = instruction[21:18];
    assign memAddr = instruction[17:2];

    // Operands read the pre-edge register value, so a register may be source and destination.
    assign op1    = sel1 ? regFile[val1[3:0]] : val1;
    assign op2    = sel2 ? regFile[val2[3:0]] : val2;
    assign regVal = regFile[memReg];

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        writeEn    = 1'b0;
        writeIdx   = dest;
        writeData  = 8'h00;
        jumpTaken  = 1'b0;
        addressOut = 16'h0000;
        valueOut   = 8'h00;
        case (opcode)
            OP_ADD: begin
                writeEn   = 1'b1;
                writeData = op1 + op2;
            end
            OP_SUB: begin
                writeEn   = 1'b1;
                writeData = op1 - op2;
            end
            OP_INV: begin
                writeEn   = 1'b1;
                writeData = ~op1;
            end
            OP_JFL:   jumpTaken = regVal[7];
            OP_JFE:   jumpTaken = (regVal == 8'h00);
            OP_JFG:   jumpTaken = !regVal[7] && (regVal != 8'h00);
            OP_JMP:   jumpTaken = 1'b1;
            OP_LOAD: begin
                writeEn    = 1'b1;
                writeIdx   = memReg;
                writeData  = valueIn;
                addressOut = memAddr;
            end
            OP_STORE: begin
                addressOut = memAddr;
                valueOut   = regVal;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            ip <= 16'h0000;
            // NOTE: the register file is flops, not a RAM, and must read zero straight out of reset.
            for (int i = 0; i < 16; i++) begin
                regFile[i] <= 8'h00;
            end
        end else begin
            // NOTE: non-blocking updates keep every read this cycle on the pre-edge state.
            ip <= jumpTaken ? memAddr : ip + 16'd1;
            if (writeEn) begin
                regFile[writeIdx] <= writeData;
            end
        end
    end

    assign instructionPointer = ip;

endmodule

// File: tb/tb_soft_cpu_control_matrix.sv
// Self-checking bench: table of instruction vectors with a scoreboard of post-edge
// expectations, plus hand-written reset-with-stopped-clock and IP wrap sequences.
module tb_soft_cpu_control_matrix;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_INV   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_JFL   = 4'b0101;
    localparam logic [3:0] OP_JFE   = 4'b0110;
    localparam logic [3:0] OP_JFG   = 4'b0111;
    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1010;

    logic        clock;
    logic        resetN;
    logic [25:0] instruction;
    logic [15:0] instructionPointer;
    logic [15:0] addressIn;
    logic [7:0]  valueIn;
    logic [15:0] addressOut;
    logic [7:0]  valueOut;
    logic        clkRun;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       name;
        logic [25:0] instr;
        logic [7:0]  vin;
        logic [15:0] expAddr;
        logic [7:0]  expVal;
        logic [15:0] expIp;
        logic        peek;
        logic [3:0]  peekIdx;
        logic [7:0]  peekVal;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] ip;
        logic        peek;
        logic [3:0]  peekIdx;
        logic [7:0]  peekVal;
    } exp_t;

    vec_t vecs[$];
    exp_t sbQ[$];

    soft_cpu_control_matrix dut (
        .clock              (clock),
        .resetN             (resetN),
        .instruction        (instruction),
        .instructionPointer (instructionPointer),
        .addressIn          (addressIn),
        .valueIn            (valueIn),
        .addressOut         (addressOut),
        .valueOut           (valueOut)
    );

    initial begin
        clock = 1'b0;
        forever begin
            #5;
            if (clkRun) clock = ~clock;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    function automatic logic [25:0] aluInstr(logic [3:0] op, logic s1, logic [7:0] v1,
                                             logic s2, logic [7:0] v2, logic [3:0] d);
        return {op, s1, v1, s2, v2, d};
    endfunction

    function automatic logic [25:0] memInstr(logic [3:0] op, logic [3:0] r, logic [15:0] a);
        return {op, r, a, 2'b11};
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reads a register through the combinational STORE data path; no clock edge involved.
    task automatic peekReg(string name, logic [3:0] idx, logic [7:0] exp);
        instruction = memInstr(OP_STORE, idx, 16'h0000);
        #1;
        check(name, {8'h00, valueOut}, {8'h00, exp});
    endtask

    task automatic addVec(string name, logic [25:0] instr, logic [7:0] vin,
                          logic [15:0] expAddr, logic [7:0] expVal, logic [15:0] expIp,
                          logic peek, logic [3:0] peekIdx, logic [7:0] peekVal);
        vec_t v;
        v.name = name; v.instr = instr; v.vin = vin; v.expAddr = expAddr; v.expVal = expVal;
        v.expIp = expIp; v.peek = peek; v.peekIdx = peekIdx; v.peekVal = peekVal;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t e;
        clkRun      = 1'b1;
        resetN      = 1'b0;
        addressIn   = 16'hA5A5;
        valueIn     = 8'h00;
        instruction = aluInstr(OP_NOP, 1'b0, 8'h00, 1'b0, 8'h00, 4'h0);

        addVec("add_imm_b",    aluInstr(OP_ADD, 0, 8'h27, 0, 8'h19, 4'd1), 8'h00, 16'h0, 8'h00, 16'h0001, 1, 4'd1, 8'h40);
        addVec("add_imm_c",    aluInstr(OP_ADD, 0, 8'h25, 0, 8'h19, 4'd2), 8'h00, 16'h0, 8'h00, 16'h0002, 1, 4'd2, 8'h3E);
        addVec("add_reg_e",    aluInstr(OP_ADD, 1, 8'hF1, 1, 8'hA2, 4'd4), 8'h00, 16'h0, 8'h00, 16'h0003, 1, 4'd4, 8'h7E);
        addVec("sub_imm_a",    aluInstr(OP_SUB, 0, 8'h7F, 0, 8'h55, 4'd0), 8'h00, 16'h0, 8'h00, 16'h0004, 1, 4'd0, 8'h2A);
        addVec("sub_wrap_b",   aluInstr(OP_SUB, 0, 8'h01, 0, 8'h0F, 4'd1), 8'h00, 16'h0, 8'h00, 16'h0005, 1, 4'd1, 8'hF2);
        addVec("inv_imm_a",    aluInstr(OP_INV, 0, 8'h55, 1, 8'h04, 4'd0), 8'h00, 16'h0, 8'h00, 16'h0006, 1, 4'd0, 8'hAA);
        addVec("inv_reg_b",    aluInstr(OP_INV, 1, 8'h00, 0, 8'h33, 4'd1), 8'h00, 16'h0, 8'h00, 16'h0007, 1, 4'd1, 8'h55);
        addVec("add_self_a",   aluInstr(OP_ADD, 1, 8'h00, 1, 8'h00, 4'd0), 8'h00, 16'h0, 8'h00, 16'h0008, 1, 4'd0, 8'h54);
        addVec("jfl_not",      memInstr(OP_JFL, 4'd1, 16'h150F), 8'h00, 16'h0, 8'h00, 16'h0009, 0, 4'd0, 8'h00);
        addVec("add_fe_b",     aluInstr(OP_ADD, 0, 8'hFE, 0, 8'h00, 4'd1), 8'h00, 16'h0, 8'h00, 16'h000A, 1, 4'd1, 8'hFE);
        addVec("jfl_taken",    memInstr(OP_JFL, 4'd1, 16'h150F), 8'h00, 16'h0, 8'h00, 16'h150F, 0, 4'd0, 8'h00);
        addVec("jfe_not_fe",   memInstr(OP_JFE, 4'd1, 16'h2000), 8'h00, 16'h0, 8'h00, 16'h1510, 0, 4'd0, 8'h00);
        addVec("sub_self_b",   aluInstr(OP_SUB, 1, 8'h01, 1, 8'h01, 4'd1), 8'h00, 16'h0, 8'h00, 16'h1511, 1, 4'd1, 8'h00);
        addVec("jfe_taken",    memInstr(OP_JFE, 4'd1, 16'h2000), 8'h00, 16'h0, 8'h00, 16'h2000, 0, 4'd0, 8'h00);
        addVec("jfl_not_zero", memInstr(OP_JFL, 4'd1, 16'h3000), 8'h00, 16'h0, 8'h00, 16'h2001, 0, 4'd0, 8'h00);
        addVec("jfg_not_zero", memInstr(OP_JFG, 4'd1, 16'h3000), 8'h00, 16'h0, 8'h00, 16'h2002, 0, 4'd0, 8'h00);
        addVec("add_7f_b",     aluInstr(OP_ADD, 0, 8'h7F, 0, 8'h00, 4'd1), 8'h00, 16'h0, 8'h00, 16'h2003, 1, 4'd1, 8'h7F);
        addVec("jfe_not_7f",   memInstr(OP_JFE, 4'd1, 16'h1111), 8'h00, 16'h0, 8'h00, 16'h2004, 0, 4'd0, 8'h00);
        addVec("jfg_taken",    memInstr(OP_JFG, 4'd1, 16'h3000), 8'h00, 16'h0, 8'h00, 16'h3000, 0, 4'd0, 8'h00);
        addVec("add_ff_b",     aluInstr(OP_ADD, 0, 8'h80, 0, 8'h7F, 4'd1), 8'h00, 16'h0, 8'h00, 16'h3001, 1, 4'd1, 8'hFF);
        addVec("jfg_not_ff",   memInstr(OP_JFG, 4'd1, 16'h4000), 8'h00, 16'h0, 8'h00, 16'h3002, 0, 4'd0, 8'h00);
        addVec("jfl_taken_ff", memInstr(OP_JFL, 4'd1, 16'h4000), 8'h00, 16'h0, 8'h00, 16'h4000, 0, 4'd0, 8'h00);
        addVec("load_c",       memInstr(OP_LOAD, 4'd2, 16'h1234), 8'h5A, 16'h1234, 8'h00, 16'h4001, 1, 4'd2, 8'h5A);
        addVec("store_c",      memInstr(OP_STORE, 4'd2, 16'h0042), 8'hC3, 16'h0042, 8'h5A, 16'h4002, 1, 4'd2, 8'h5A);
        addVec("nop_f",        aluInstr(4'hF, 1, 8'hFF, 1, 8'hFF, 4'd4), 8'h11, 16'h0, 8'h00, 16'h4003, 1, 4'd4, 8'h7E);
        addVec("jmp_ffff",     memInstr(OP_JMP, 4'd3, 16'hFFFF), 8'h00, 16'h0, 8'h00, 16'hFFFF, 0, 4'd0, 8'h00);
        addVec("nop_wrap",     aluInstr(OP_NOP, 0, 8'h00, 0, 8'h00, 4'd0), 8'h00, 16'h0, 8'h00, 16'h0000, 0, 4'd0, 8'h00);
        addVec("nop_4",        aluInstr(4'h4, 0, 8'h12, 0, 8'h34, 4'd0), 8'h00, 16'h0, 8'h00, 16'h0001, 1, 4'd0, 8'h54);

        // Reset state, with the clock running but reset held.
        #1;
        check("reset_ip", instructionPointer, 16'h0000);
        check("reset_addr_nop", addressOut, 16'h0000);
        peekReg("reset_r3", 4'd3, 8'h00);
        @(negedge clock);
        resetN = 1'b1;

        foreach (vecs[i]) begin
            instruction = vecs[i].instr;
            valueIn     = vecs[i].vin;
            #1;
            check({vecs[i].name, "_addrOut"}, addressOut, vecs[i].expAddr);
            check({vecs[i].name, "_valOut"}, {8'h00, valueOut}, {8'h00, vecs[i].expVal});
            e.name = vecs[i].name; e.ip = vecs[i].expIp; e.peek = vecs[i].peek;
            e.peekIdx = vecs[i].peekIdx; e.peekVal = vecs[i].peekVal;
            sbQ.push_back(e);
            @(posedge clock);
            #1;
            if (sbQ.size() == 0) begin
                total++;
                $display("FAIL %s_scoreboard: queue empty, expected one entry", vecs[i].name);
            end else begin
                e = sbQ.pop_front();
                check({e.name, "_ip"}, instructionPointer, e.ip);
                if (e.peek) peekReg({e.name, "_reg"}, e.peekIdx, e.peekVal);
            end
        end

        // Mid-stream reset with the clock stopped: state clears at once, in-flight ADD is lost.
        instruction = aluInstr(OP_ADD, 0, 8'h01, 0, 8'h01, 4'd6);
        @(negedge clock);
        clkRun = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        check("async_reset_ip", instructionPointer, 16'h0000);
        for (int r = 0; r < 16; r++) begin
            peekReg($sformatf("async_reset_r%0d", r), r[3:0], 8'h00);
        end
        instruction = memInstr(OP_STORE, 4'd2, 16'hBEEF);
        #1;
        check("reset_store_addr", addressOut, 16'hBEEF);
        check("reset_store_val", {8'h00, valueOut}, 16'h0000);
        instruction = aluInstr(OP_ADD, 0, 8'h03, 0, 8'h04, 4'd5);
        #2;
        resetN = 1'b1;
        #2;
        check("held_ip_after_release", instructionPointer, 16'h0000);
        clkRun = 1'b1;
        @(posedge clock);
        #1;
        check("first_after_reset_ip", instructionPointer, 16'h0001);
        peekReg("first_after_reset_r5", 4'd5, 8'h07);
        peekReg("discarded_r6", 4'd6, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
